// File: rtl/traffic_light_monitor.sv
// Passive lamp-bus checker: decodes lamps into phases, times them in ticks and
// latches the first fault. Macro STRICT_SEQ_EN enables the phase-order check (code 2).
module traffic_light_monitor #(
  parameter int CNT_W       = 8,
  parameter int MIN_GREEN   = 6,
  parameter int MAX_GREEN   = 9,
  parameter int YELLOW_SECS = 2,
  parameter int WALK_SECS   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [6:0]       lamps,
  input  logic             clear_fault,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] phase_secs,
  output logic             fault,
  output logic [2:0]       fault_code
);

  typedef enum logic [2:0] {
    PH_INIT = 3'd0,
    PH_MG   = 3'd1,
    PH_MY   = 3'd2,
    PH_WALK = 3'd3,
    PH_SG   = 3'd4,
    PH_SY   = 3'd5
  } phase_e;

  // Bit order {mainR,mainY,mainG,sideR,sideY,sideG,walk}
  localparam logic [6:0] LAMPS_MG   = 7'b0011000;
  localparam logic [6:0] LAMPS_MY   = 7'b0101000;
  localparam logic [6:0] LAMPS_WALK = 7'b1001001;
  localparam logic [6:0] LAMPS_SG   = 7'b1000010;
  localparam logic [6:0] LAMPS_SY   = 7'b1000100;

  localparam logic [CNT_W-1:0] SECS_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G    = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL      = CNT_W'(YELLOW_SECS);
  localparam logic [CNT_W-1:0] WALK_T   = CNT_W'(WALK_SECS);

  logic [6:0]       lamps_q;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] secs_q, secs_d;
  logic             first_q, first_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;

  phase_e     lamp_phase;
  logic       lamp_legal;
  logic       in_green;
  logic [6:1] det;
  logic [2:0] det_code;

`ifdef STRICT_SEQ_EN
  function automatic logic order_ok(input phase_e from, input phase_e to);
    case (from)
      PH_MG:   order_ok = (to == PH_MY);
      PH_MY:   order_ok = (to == PH_SG) || (to == PH_WALK);
      PH_WALK: order_ok = (to == PH_SG);
      PH_SG:   order_ok = (to == PH_SY);
      PH_SY:   order_ok = (to == PH_MG);
      default: order_ok = 1'b1;
    endcase
  endfunction
`endif

  always_comb begin : decode
    lamp_legal = 1'b1;
    lamp_phase = PH_INIT;
    case (lamps_q)
      LAMPS_MG:   lamp_phase = PH_MG;
      LAMPS_MY:   lamp_phase = PH_MY;
      LAMPS_WALK: lamp_phase = PH_WALK;
      LAMPS_SG:   lamp_phase = PH_SG;
      LAMPS_SY:   lamp_phase = PH_SY;
      default:    lamp_legal = 1'b0;
    endcase
  end

  assign in_green = (phase_q == PH_MG) || (phase_q == PH_SG);

  always_comb begin : next_state
    phase_d   = phase_q;
    secs_d    = secs_q;
    first_d   = first_q;
    illegal_d = ~lamp_legal;
    det       = '0;
    // An illegal vector only counts once it has been seen on two consecutive clocks
    det[1]    = ~lamp_legal & illegal_q;
    if (lamp_legal && (lamp_phase != phase_q)) begin
      phase_d = lamp_phase;
      secs_d  = tick ? CNT_W'(1) : '0;
      first_d = (phase_q == PH_INIT);
      if (phase_q != PH_INIT) begin
`ifdef STRICT_SEQ_EN
        det[2] = ~order_ok(phase_q, lamp_phase);
`endif
        // The phase entered straight from INIT may be partial, so its length is not judged
        if (!first_q) begin
          case (phase_q)
            PH_MY, PH_SY: det[3] = (secs_q != YEL);
            PH_MG, PH_SG: begin
              det[4] = (secs_q < MIN_G);
              det[5] = (secs_q > MAX_G);
            end
            PH_WALK:      det[6] = (secs_q != WALK_T);
            default:      ;
          endcase
        end
      end
    end else if (tick) begin
      if (secs_q != SECS_MAX) secs_d = secs_q + 1'b1;
      det[5] = in_green && (secs_q == MAX_G);
    end
  end

  always_comb begin : fault_select
    det_code = '0;
    for (int i = 6; i >= 1; i--) begin
      if (det[i]) det_code = 3'(i);
    end
    fault_d = fault_q;
    code_d  = code_q;
    if (clear_fault) begin
      fault_d = 1'b0;
      code_d  = '0;
    end
    // A fresh detection beats a coincident clear; an existing fault is never overwritten
    if ((det_code != '0) && (!fault_q || clear_fault)) begin
      fault_d = 1'b1;
      code_d  = det_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamps_q   <= '0;
      phase_q   <= PH_INIT;
      secs_q    <= '0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      lamps_q   <= lamps;
      phase_q   <= phase_d;
      secs_q    <= secs_d;
      first_q   <= first_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
    end
  end

  assign phase      = phase_q;
  assign phase_secs = secs_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios with literal
// expectations, then randomized lamp/tick/clear traffic compared every cycle against a model.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN = 6, MAX_GREEN = 9, YELLOW_SECS = 2, WALK_SECS = 3;
  localparam logic [6:0] MG = 7'b0011000, MY = 7'b0101000, WK = 7'b1001001,
                         SG = 7'b1000010, SY = 7'b1000100;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, clear_fault = 1'b0;
  logic [6:0] lamps = MG;
  logic [2:0] phase, fault_code;
  logic [7:0] phase_secs;
  logic       fault;

  int checks = 0, errors = 0;
  bit started = 0;

  traffic_light_monitor dut (
    .clk(clk), .reset(rst), .tick(tick), .lamps(lamps), .clear_fault(clear_fault),
    .phase(phase), .phase_secs(phase_secs), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  logic [6:0] vec [6];
  int unsigned succ_mask [6];
  initial begin
    vec[0] = 7'h7f; vec[1] = MG; vec[2] = MY; vec[3] = WK; vec[4] = SG; vec[5] = SY;
    succ_mask[0] = 0; succ_mask[1] = 1 << 2; succ_mask[2] = (1 << 4) | (1 << 3);
    succ_mask[3] = 1 << 4; succ_mask[4] = 1 << 5; succ_mask[5] = 1 << 1;
  end

  function automatic int phase_of(input logic [6:0] v);
    for (int p = 1; p < 6; p++) if (vec[p] == v) return p;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_lq is the lamp sample the monitor currently sees.
  int m_phase = 0, m_secs = 0, m_fault = 0, m_code = 0, m_first = 0, m_run = 0;
  logic [6:0] m_lq = '0;

  always @(posedge clk or posedge rst) begin
    int cur, det;
    if (rst) begin
      m_phase = 0; m_secs = 0; m_fault = 0; m_code = 0; m_first = 0; m_run = 0; m_lq = '0;
    end else begin
      det = 0;
      cur = phase_of(m_lq);
      m_run = (cur == 0) ? m_run + 1 : 0;
      if (m_run >= 2) det = 1;
      if (cur != 0 && cur != m_phase) begin
        if (m_phase != 0) begin
`ifdef STRICT_SEQ_EN
          if (((succ_mask[m_phase] >> cur) & 1) == 0 && (det == 0 || det > 2)) det = 2;
`endif
          if (m_first == 0) begin
            int c;
            c = 0;
            if ((m_phase == 2 || m_phase == 5) && m_secs != YELLOW_SECS) c = 3;
            if ((m_phase == 1 || m_phase == 4) && m_secs < MIN_GREEN) c = 4;
            if ((m_phase == 1 || m_phase == 4) && m_secs > MAX_GREEN) c = 5;
            if (m_phase == 3 && m_secs != WALK_SECS) c = 6;
            if (c != 0 && (det == 0 || c < det)) det = c;
          end
        end
        m_first = (m_phase == 0);
        m_phase = cur;
        m_secs = tick ? 1 : 0;
      end else if (tick) begin
        if (m_secs < 255) m_secs++;
        if ((m_phase == 1 || m_phase == 4) && m_secs == MAX_GREEN + 1 && (det == 0 || det > 5))
          det = 5;
      end
      if (clear_fault) begin m_fault = 0; m_code = 0; end
      if (det != 0 && (m_fault == 0 || clear_fault)) begin m_fault = 1; m_code = det; end
      m_lq = lamps;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("phase", int'(phase), m_phase);
      check("phase_secs", int'(phase_secs), m_secs);
      check("fault", int'(fault), m_fault);
      check("fault_code", int'(fault_code), m_code);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lamps = MG; tick = 1'b0; clear_fault = 1'b0;
    cyc(); cyc();
    check("rst_phase", int'(phase), 0);
    check("rst_secs", int'(phase_secs), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    rst = 1'b0;
  endtask

  task automatic hold(input logic [6:0] v, input int n);
    lamps = v;
    repeat (n) begin
      repeat (3) cyc();
      tick = 1'b1; cyc(); tick = 1'b0;
    end
  endtask

  function automatic int next_legal(input int p);
    case (p)
      1: return 2;
      2: return ($urandom % 2) ? 4 : 3;
      3: return 4;
      4: return 5;
      default: return 1;
    endcase
  endfunction

  initial begin
    int cur, seg_left, glitch_left;
    #1;
    started = 1;
    // Normal cycle: phases 1,2,4,5,1 with no fault
    do_reset();
    hold(MG, 7); check("t1_mg", int'(phase), 1);
    hold(MY, 2); check("t1_my", int'(phase), 2);
    hold(SG, 7); check("t1_sg", int'(phase), 4);
    hold(SY, 2); check("t1_sy", int'(phase), 5);
    hold(MG, 1); check("t1_mg2", int'(phase), 1);
    check("t1_fault", int'(fault), 0);
    // Yellow too long
    do_reset();
    hold(MG, 7); hold(MY, 3); check("t2_nofault", int'(fault), 0);
    hold(SG, 1); check("t2_fault", int'(fault), 1); check("t2_code", int'(fault_code), 3);
    // One-clock glitch ignored, two-clock glitch flagged
    do_reset();
    hold(MG, 2);
    lamps = MG | 7'b0000010; cyc(); hold(MG, 1); check("t3_glitch1", int'(fault), 0);
    lamps = MG | 7'b0000010; cyc(); cyc(); hold(MG, 1);
    check("t3_code", int'(fault_code), 1); check("t3_phase", int'(phase), 1);
    // Out-of-order, short green
    do_reset();
    hold(MG, 7); hold(MY, 2); hold(SG, 3); hold(MG, 1);
`ifdef STRICT_SEQ_EN
    check("t4_code", int'(fault_code), 2);
`else
    check("t4_code", int'(fault_code), 4);
`endif
    // Green overrun flagged immediately, then cleared
    do_reset();
    hold(MG, 10);
    check("t5_secs", int'(phase_secs), 10); check("t5_code", int'(fault_code), 5);
    clear_fault = 1'b1; cyc(); clear_fault = 1'b0; cyc();
    check("t5_clr_fault", int'(fault), 0); check("t5_clr_code", int'(fault_code), 0);
    // Walk path: correct then short
    do_reset();
    hold(MG, 7); hold(MY, 2); hold(WK, 3); hold(SG, 7); hold(SY, 2); hold(MG, 7);
    check("t6_clean", int'(fault), 0);
    hold(MY, 2); hold(WK, 2); hold(SG, 1);
    check("t6_code", int'(fault_code), 6);

    // Randomized traffic
    for (int round = 0; round < 4; round++) begin
      do_reset();
      cur = 1; seg_left = 4 + $urandom % 44; glitch_left = 0;
      repeat (600) begin
        if (seg_left == 0) begin
          cur = ($urandom % 10 < 7) ? next_legal(cur) : 1 + $urandom % 5;
          seg_left = 4 + $urandom % 44;
        end
        if (glitch_left == 0 && $urandom % 50 == 0) glitch_left = 1 + $urandom % 3;
        if (glitch_left > 0) begin
          lamps = vec[cur] ^ (7'b1 << ($urandom % 7));
          glitch_left--;
        end else begin
          lamps = vec[cur];
        end
        tick = ($urandom % 4 == 0);
        clear_fault = ($urandom % 40 == 0);
        cyc();
        seg_left--;
      end
      tick = 1'b0; clear_fault = 1'b0;
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
